mul_share_arbiter: RTL and testbench

Round-robin arbiter that shares one pipelined signed multiplier among N_REQ scheduled datapath FSMs.
- Each HLSM instance issues multiply requests in its multiply states instead of owning a private multiplier.
- The block grants at most one requester per cycle and launches its operands into a MUL_LAT-stage multiplier.
- It returns the truncated product to the granted requester exactly MUL_LAT cycles later.
- It sits between the generated HLSM controllers and the single shared multiplier resource.

---
 rtl/hls_pkg.sv | 18 +
 rtl/mul_share_arbiter_if.sv | 28 ++
 rtl/mul_pipe.sv | 64 ++++++
 rtl/mul_share_arbiter.sv | 104 ++++++++++
 tb/tb_mul_share_arbiter.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/hls_pkg.sv
// Shared constants and types for the scheduled-datapath blocks that borrow
// the common multiplier.
package hls_pkg;

  localparam int DEFAULT_N_REQ   = 4;
  localparam int DEFAULT_WIDTH   = 16;
  localparam int DEFAULT_MUL_LAT = 2;
  localparam int MAX_REQ         = 8;

  // Requester index wide enough for the largest supported arbiter
  typedef logic [$clog2(MAX_REQ)-1:0] req_idx_t;

  // Tag/pointer width for n_req requesters; never narrower than one bit
  function automatic int tag_width(input int n_req);
    return (n_req <= 2) ? 1 : $clog2(n_req);
  endfunction

endpackage

// File: rtl/mul_share_arbiter_if.sv
// Request/grant/response bundle between the HLSM controllers (master side)
// and the shared-multiplier arbiter (slave side).
interface mul_share_arbiter_if
  import hls_pkg::*;
#(
  parameter int N_REQ = DEFAULT_N_REQ,
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] op_a;
  logic [N_REQ*WIDTH-1:0] op_b;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]       rsp_data;
  logic                   busy;

  modport master (
    output req, op_a, op_b,
    input  gnt, rsp_valid, rsp_data, busy
  );

  modport slave (
    input  req, op_a, op_b,
    output gnt, rsp_valid, rsp_data, busy
  );

endinterface

// File: rtl/mul_pipe.sv
// Signed WIDTH x WIDTH multiplier with MUL_LAT register stages; each stage
// carries a valid bit and the requester tag, and the product is truncated.
module mul_pipe
  import hls_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int MUL_LAT = DEFAULT_MUL_LAT,
  parameter int TAG_W   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid_i,
  input  logic signed [WIDTH-1:0] in_a_i,
  input  logic signed [WIDTH-1:0] in_b_i,
  input  logic [TAG_W-1:0]        in_tag_i,
  output logic                    out_valid_o,
  output logic [TAG_W-1:0]        out_tag_o,
  output logic [WIDTH-1:0]        out_data_o,
  output logic                    busy_o
);

  logic signed [2*WIDTH-1:0] full_prod;
  logic [WIDTH-1:0]          prod_trunc;

  logic [MUL_LAT-1:0] vld_q;
  logic [WIDTH-1:0]   dat_q [MUL_LAT];
  logic [TAG_W-1:0]   tag_q [MUL_LAT];

  // Operands sign-extend to 2*WIDTH before multiplying; only the low half is kept
  assign full_prod  = in_a_i * in_b_i;
  assign prod_trunc = full_prod[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      // NOTE: stage data is reset too, not just the valids: the last stage
      // drives rsp_data directly and must read 0 from reset onward.
      for (int s = 0; s < MUL_LAT; s++) begin
        dat_q[s] <= '0;
        tag_q[s] <= '0;
      end
    end else begin
      vld_q[0] <= in_valid_i;
      if (in_valid_i) begin
        dat_q[0] <= prod_trunc;
        tag_q[0] <= in_tag_i;
      end
      // Payload only moves with a valid, so the last stage holds its product
      for (int s = 1; s < MUL_LAT; s++) begin
        vld_q[s] <= vld_q[s-1];
        if (vld_q[s-1]) begin
          dat_q[s] <= dat_q[s-1];
          tag_q[s] <= tag_q[s-1];
        end
      end
    end
  end

  assign out_valid_o = vld_q[MUL_LAT-1];
  assign out_tag_o   = tag_q[MUL_LAT-1];
  assign out_data_o  = dat_q[MUL_LAT-1];
  assign busy_o      = |vld_q;

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one pipelined signed multiplier among N_REQ
// requesters; the product returns to the granted requester MUL_LAT cycles later.
module mul_share_arbiter
  import hls_pkg::*;
#(
  parameter int N_REQ   = DEFAULT_N_REQ,
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int MUL_LAT = DEFAULT_MUL_LAT
) (
  input  logic                Clk,
  input  logic                Rst,
  mul_share_arbiter_if.slave  bus
);

  localparam int TAG_W = tag_width(N_REQ);

  logic [TAG_W-1:0] ptr_q, ptr_d;
  logic [TAG_W:0]   search_sum;
  logic [TAG_W-1:0] search_idx;
  req_idx_t         win;
  logic             found;
  logic             launch;
  logic [N_REQ-1:0] gnt_onehot;

  logic             pipe_vld;
  logic [TAG_W-1:0] pipe_tag;
  logic [WIDTH-1:0] pipe_data;
  logic             pipe_busy;
  logic [N_REQ-1:0] rsp_onehot;

  // First asserted request at or after ptr, wrapping modulo N_REQ
  always_comb begin
    // NOTE: every variable gets a default before the loop so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    found      = 1'b0;
    win        = '0;
    search_sum = '0;
    search_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      search_sum = {1'b0, ptr_q} + (TAG_W+1)'(k);
      if (search_sum >= (TAG_W+1)'(N_REQ)) begin
        search_sum = search_sum - (TAG_W+1)'(N_REQ);
      end
      search_idx = search_sum[TAG_W-1:0];
      if (!found && bus.req[search_idx]) begin
        found = 1'b1;
        win   = req_idx_t'(search_idx);
      end
    end
  end

  // Grant is suppressed while reset is held, so nothing launches then
  assign launch = found & Rst;

  always_comb begin
    gnt_onehot = '0;
    ptr_d      = ptr_q;
    if (launch) begin
      gnt_onehot[win] = 1'b1;
      ptr_d = (win == req_idx_t'(N_REQ-1)) ? '0 : TAG_W'(win + 1'b1);
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      ptr_q <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop
      // samples the pre-edge value regardless of process ordering.
      ptr_q <= ptr_d;
    end
  end

  mul_pipe #(
    .WIDTH   (WIDTH),
    .MUL_LAT (MUL_LAT),
    .TAG_W   (TAG_W)
  ) u_mul_pipe (
    .clk         (Clk),
    .rst_n       (Rst),
    .in_valid_i  (launch),
    .in_a_i      (bus.op_a[win*WIDTH +: WIDTH]),
    .in_b_i      (bus.op_b[win*WIDTH +: WIDTH]),
    .in_tag_i    (win[TAG_W-1:0]),
    .out_valid_o (pipe_vld),
    .out_tag_o   (pipe_tag),
    .out_data_o  (pipe_data),
    .busy_o      (pipe_busy)
  );

  // Response decode straight from the last pipeline stage's flops
  always_comb begin
    rsp_onehot = '0;
    if (pipe_vld) begin
      rsp_onehot[pipe_tag] = 1'b1;
    end
  end

  assign bus.gnt       = gnt_onehot;
  assign bus.rsp_valid = rsp_onehot;
  assign bus.rsp_data  = pipe_data;
  assign bus.busy      = pipe_busy;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter (N_REQ=4, WIDTH=16, MUL_LAT=2) with
// hand-computed grants, products and response timing.
module tb_mul_share_arbiter;
  import hls_pkg::*;

  localparam int N = 4;
  localparam int W = 16;
  localparam int L = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mul_share_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus_if ();

  mul_share_arbiter #(.N_REQ(N), .WIDTH(W), .MUL_LAT(L)) dut (
    .Clk (clk),
    .Rst (rst_n),
    .bus (bus_if)
  );

  int total = 0;
  int bad   = 0;

  logic [15:0] prod_tab [4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
    bus_if.op_a[i*W +: W] = a;
    bus_if.op_b[i*W +: W] = b;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n       = 1'b0;
    bus_if.req  = '0;
    bus_if.op_a = '0;
    bus_if.op_b = '0;
    tick();

    // Reset state, with requests asserted to show grant is forced low
    bus_if.req = 4'b1111;
    #1;
    check("rst_gnt", bus_if.gnt, 0);
    check("rst_rsp_valid", bus_if.rsp_valid, 0);
    check("rst_rsp_data", bus_if.rsp_data, 0);
    check("rst_busy", bus_if.busy, 0);
    bus_if.req = '0;
    tick();
    rst_n = 1'b1;
    tick();
    check("idle_busy", bus_if.busy, 0);

    // Single request: 7 * -3 = -21
    set_op(1, 16'd7, 16'hFFFD);
    bus_if.req = 4'b0010;
    #1;
    check("single_gnt_c0", bus_if.gnt, 4'b0010);
    check("single_busy_c0", bus_if.busy, 0);
    tick();
    bus_if.req = '0;
    #1;
    check("single_gnt_c1", bus_if.gnt, 0);
    check("single_busy_c1", bus_if.busy, 1);
    check("single_rsp_c1", bus_if.rsp_valid, 0);
    tick();
    check("single_rsp_c2", bus_if.rsp_valid, 4'b0010);
    check("single_data_c2", bus_if.rsp_data, 16'hFFEB);
    check("single_busy_c2", bus_if.busy, 1);
    tick();
    check("single_rsp_c3", bus_if.rsp_valid, 0);
    check("single_busy_c3", bus_if.busy, 0);
    check("single_hold_c3", bus_if.rsp_data, 16'hFFEB);

    // All four held from ptr=0: products 2*10, 3*20, 4*30, 5*40
    do_reset();
    prod_tab[0] = 16'd20;
    prod_tab[1] = 16'd60;
    prod_tab[2] = 16'd120;
    prod_tab[3] = 16'd200;
    set_op(0, 16'd2, 16'd10);
    set_op(1, 16'd3, 16'd20);
    set_op(2, 16'd4, 16'd30);
    set_op(3, 16'd5, 16'd40);
    bus_if.req = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      #1;
      check($sformatf("rr_gnt_c%0d", c), bus_if.gnt, 32'(1 << (c % 4)));
      if (c >= 2) begin
        check($sformatf("rr_rsp_c%0d", c), bus_if.rsp_valid, 32'(1 << ((c - 2) % 4)));
        check($sformatf("rr_data_c%0d", c), bus_if.rsp_data, prod_tab[(c - 2) % 4]);
      end else begin
        check($sformatf("rr_rsp_c%0d", c), bus_if.rsp_valid, 0);
      end
      tick();
    end
    bus_if.req = '0;
    #1;
    check("rr_drain_rsp_c8", bus_if.rsp_valid, 4'b0100);
    check("rr_drain_data_c8", bus_if.rsp_data, 16'd120);
    tick();
    check("rr_drain_rsp_c9", bus_if.rsp_valid, 4'b1000);
    check("rr_drain_data_c9", bus_if.rsp_data, 16'd200);
    tick();
    check("rr_drain_rsp_c10", bus_if.rsp_valid, 0);
    check("rr_drain_busy_c10", bus_if.busy, 0);

    // Truncation: 300*300 = 90000 -> 24464; -32768 * -1 -> -32768
    set_op(0, 16'd300, 16'd300);
    set_op(1, 16'h8000, 16'hFFFF);
    bus_if.req = 4'b0001;
    #1;
    check("trunc_gnt0", bus_if.gnt, 4'b0001);
    tick();
    bus_if.req = 4'b0010;
    #1;
    check("trunc_gnt1", bus_if.gnt, 4'b0010);
    tick();
    bus_if.req = '0;
    check("trunc_rsp0", bus_if.rsp_valid, 4'b0001);
    check("trunc_data0", bus_if.rsp_data, 16'd24464);
    tick();
    check("trunc_rsp1", bus_if.rsp_valid, 4'b0010);
    check("trunc_data1", bus_if.rsp_data, 16'h8000);
    tick();
    check("trunc_rsp_end", bus_if.rsp_valid, 0);

    // Wrap-around from ptr=2: grant 3, then 0 before 2
    set_op(3, 16'd3, 16'd3);
    set_op(0, 16'hFFFB, 16'd6);
    set_op(2, 16'd100, 16'hFF9C);
    bus_if.req = 4'b1000;
    #1;
    check("wrap_gnt3", bus_if.gnt, 4'b1000);
    tick();
    bus_if.req = 4'b0101;
    #1;
    check("wrap_gnt0", bus_if.gnt, 4'b0001);
    tick();
    #1;
    check("wrap_gnt2", bus_if.gnt, 4'b0100);
    check("wrap_rsp3", bus_if.rsp_valid, 4'b1000);
    check("wrap_data3", bus_if.rsp_data, 16'd9);
    tick();
    bus_if.req = '0;
    check("wrap_rsp0", bus_if.rsp_valid, 4'b0001);
    check("wrap_data0", bus_if.rsp_data, 16'hFFE2);
    tick();
    check("wrap_rsp2", bus_if.rsp_valid, 4'b0100);
    check("wrap_data2", bus_if.rsp_data, 16'hD8F0);
    tick();
    check("wrap_busy_end", bus_if.busy, 0);

    // Reset mid-operation: grant 2, Rst low in cycle 1, released in cycle 3
    bus_if.req = 4'b0100;
    #1;
    check("rstmid_gnt_c0", bus_if.gnt, 4'b0100);
    tick();
    check("rstmid_busy_c1", bus_if.busy, 1);
    rst_n = 1'b0;
    #1;
    check("rstmid_gnt_forced", bus_if.gnt, 0);
    check("rstmid_busy_low", bus_if.busy, 0);
    check("rstmid_data_zero", bus_if.rsp_data, 0);
    check("rstmid_rsp_c1", bus_if.rsp_valid, 0);
    bus_if.req = '0;
    tick();
    check("rstmid_rsp_c2", bus_if.rsp_valid, 0);
    check("rstmid_busy_c2", bus_if.busy, 0);
    tick();
    rst_n = 1'b1;
    #1;
    check("rstmid_rsp_c3", bus_if.rsp_valid, 0);
    check("rstmid_data_c3", bus_if.rsp_data, 0);
    tick();
    check("rstmid_rsp_c4", bus_if.rsp_valid, 0);
    check("rstmid_busy_c4", bus_if.busy, 0);
    bus_if.req = 4'b1111;
    #1;
    check("rstmid_ptr0_gnt", bus_if.gnt, 4'b0001);
    tick();
    bus_if.req = '0;
    tick();
    check("rstmid_new_rsp", bus_if.rsp_valid, 4'b0001);
    check("rstmid_new_data", bus_if.rsp_data, 16'hFFE2);
    tick();

    // Withdrawn request: 3 pulses while 1 holds the grant (ptr=1)
    check("idle_busy_pre", bus_if.busy, 0);
    set_op(1, 16'hFFF9, 16'hFFF8);
    bus_if.req = 4'b1010;
    #1;
    check("wd_gnt1", bus_if.gnt, 4'b0010);
    tick();
    bus_if.req = '0;
    #1;
    check("wd_gnt_none", bus_if.gnt, 0);
    check("wd_busy_c1", bus_if.busy, 1);
    tick();
    check("wd_rsp1", bus_if.rsp_valid, 4'b0010);
    check("wd_data1", bus_if.rsp_data, 16'd56);
    tick();
    check("wd_no_launch_rsp", bus_if.rsp_valid, 0);
    check("wd_no_launch_busy", bus_if.busy, 0);
    tick();
    check("wd_idle_busy", bus_if.busy, 0);
    bus_if.req = 4'b1001;
    #1;
    check("wd_ptr2_gnt", bus_if.gnt, 4'b1000);
    tick();
    bus_if.req = '0;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
